// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command
// bytes and the host-to-device frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] BREAK_CODE  = 8'hF0;

  // Bits 0..7 data (LSB first on the wire), bit 8 odd parity, bit 9 stop.
  function automatic logic [9:0] make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Synchroniser for the raw PS/2 lines: 3-flop clock chain with falling-edge
// detect and 2-flop data chain. Also usable by the keyboard receiver.
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_s,
  output logic o_data_s,
  output logic o_neg_edge
);

  logic [2:0] r_clk;
  logic [1:0] r_data;

  // Reset to the idle-high line level so no false edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk  <= '1;
      r_data <= '1;
    end else begin
      r_clk  <= {r_clk[1:0], i_ps2_clk};
      r_data <= {r_data[0], i_ps2_data};
    end
  end

  assign o_clk_s    = r_clk[1];
  assign o_data_s   = r_data[1];
  assign o_neg_edge = ~r_clk[1] & r_clk[2];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10-bit shift
// on device clock falling edges, ACK sample, then wait for bus idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC = 6000,
  parameter int unsigned RTS_CYC     = 100,
  parameter int unsigned TIMEOUT_CYC = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       ps2k_clk_oe,
  output logic       ps2k_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_err
);

  localparam logic [19:0] L_INH_LAST = 20'(INHIBIT_CYC - 1);
  localparam logic [19:0] L_RTS_LAST = 20'(RTS_CYC - 1);
  localparam logic [19:0] L_TO_LAST  = 20'(TIMEOUT_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_frame, w_frame_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [19:0] r_cnt, w_cnt_nxt;
  logic        r_data_oe, w_data_oe_nxt;
  logic        r_ack_ok, w_ack_ok_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;

  logic        w_clk_s, w_data_s, w_neg_edge;
  logic [19:0] w_cnt_inc;
  logic        w_timeout;

  ps2_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ps2_clk  (ps2k_clk),
    .i_ps2_data (ps2k_data),
    .o_clk_s    (w_clk_s),
    .o_data_s   (w_data_s),
    .o_neg_edge (w_neg_edge)
  );

  // Saturating so a stuck bus can never wrap back below the timeout limit.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 20'd1;
  assign w_timeout = (r_cnt >= L_TO_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_nxt   = r_frame;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_data_oe_nxt = r_data_oe;
    w_ack_ok_nxt  = r_ack_ok;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        w_data_oe_nxt = 1'b0;
        if (tx_valid) begin
          w_state_nxt  = INHIBIT;
          w_frame_nxt  = make_frame(tx_data);
          w_idx_nxt    = '0;
          w_cnt_nxt    = '0;
          w_ack_ok_nxt = 1'b0;
        end
      end

      INHIBIT: begin
        if (r_cnt == L_INH_LAST) begin
          w_state_nxt   = RTS;
          w_cnt_nxt     = '0;
          w_data_oe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      RTS: begin
        if (r_cnt == L_RTS_LAST) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      SHIFT: begin
        if (w_neg_edge) begin
          w_data_oe_nxt = ~r_frame[r_idx];
          w_idx_nxt     = r_idx + 4'd1;
          w_cnt_nxt     = '0;
          if (r_idx == 4'd9) w_state_nxt = ACK;
        end else if (w_timeout) begin
          w_state_nxt   = IDLE;
          w_data_oe_nxt = 1'b0;
          w_ack_ok_nxt  = 1'b0;
          w_cnt_nxt     = '0;
          w_err_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      ACK: begin
        if (w_neg_edge) begin
          w_ack_ok_nxt = ~w_data_s;
          w_cnt_nxt    = '0;
          w_state_nxt  = WAIT_IDLE;
        end else if (w_timeout) begin
          w_state_nxt   = IDLE;
          w_data_oe_nxt = 1'b0;
          w_ack_ok_nxt  = 1'b0;
          w_cnt_nxt     = '0;
          w_err_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      WAIT_IDLE: begin
        if (w_clk_s && w_data_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt   = IDLE;
          w_data_oe_nxt = 1'b0;
          w_ack_ok_nxt  = 1'b0;
          w_cnt_nxt     = '0;
          w_err_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_data_oe_nxt = 1'b0;
        w_cnt_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_frame   <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_data_oe <= 1'b0;
      r_ack_ok  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_frame   <= w_frame_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_ack_ok  <= w_ack_ok_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Clock enable decodes straight from the state register so an async reset
  // releases the line without waiting for a clock edge.
  assign ps2k_clk_oe  = (r_state == INHIBIT) || (r_state == RTS);
  assign ps2k_data_oe = r_data_oe;
  assign tx_ready     = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign tx_done      = r_done;
  assign tx_err       = r_err;
  assign tx_ack_ok    = r_ack_ok;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain keyboard model and a
// scoreboard of expected wire frames.
module tb_ps2_host_tx;

  localparam int H  = 40;    // device clock half period in clk cycles
  localparam int TO = 2000;  // shortened timeout for simulation

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, ps2k_clk_oe, ps2k_data_oe, busy, tx_done, tx_ack_ok, tx_err;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2k_clk_line, ps2k_data_line;
  assign ps2k_clk_line  = ~(ps2k_clk_oe | dev_clk_low);
  assign ps2k_data_line = ~(ps2k_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYC(6000),
    .RTS_CYC    (100),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2k_clk    (ps2k_clk_line),
    .ps2k_data   (ps2k_data_line),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2k_clk_oe (ps2k_clk_oe),
    .ps2k_data_oe(ps2k_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_ack_ok   (tx_ack_ok),
    .tx_err      (tx_err)
  );

  int checks = 0;
  int errors = 0;

  // Device model controls (written by the main sequence only).
  int   dev_arm = 0;
  int   dev_edges = 11;
  logic dev_ack = 1'b1;
  // Device model results (written by the device process only).
  int         dev_served = 0;
  logic [9:0] rx_vec = '0;

  // Monitor results.
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0, acc_at_done = 0;
  int inh_run = 0, rts_run = 0, inh_len = 0, rts_len = 0;

  logic [9:0] exp_q[$];

  always @(posedge clk)
    if (rst_n && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (tx_done) acc_at_done <= acc_cnt;
    if (ps2k_clk_oe && !ps2k_data_oe) inh_run <= inh_run + 1;
    else begin
      if (inh_run != 0) inh_len <= inh_run;
      inh_run <= 0;
    end
    if (ps2k_clk_oe && ps2k_data_oe) rts_run <= rts_run + 1;
    else begin
      if (rts_run != 0) rts_len <= rts_run;
      rts_run <= 0;
    end
  end

  // Keyboard model: once the host releases the clock with data low, clock out
  // dev_edges falling edges, sample on each rising edge, optionally ACK.
  initial begin
    forever begin
      @(negedge clk);
      if (dev_arm != dev_served && rst_n && !ps2k_clk_oe && ps2k_data_oe && busy) begin
        rx_vec = '0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < dev_edges; i++) begin
          dev_clk_low = 1'b1;
          repeat (H) @(negedge clk);
          dev_clk_low = 1'b0;
          if (i < 10) rx_vec[i] = ps2k_data_line;
          if (i == 9) dev_data_low = dev_ack;
          repeat (H) @(negedge clk);
        end
        dev_data_low = 1'b0;
        dev_served = dev_served + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] exp_bits(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!tx_ready && k < 20000) begin @(negedge clk); k++; end
    check("ready_bound", 32'(k < 20000), 32'd1);
  endtask

  task automatic send(input logic [7:0] d);
    wait_ready();
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    exp_q.push_back(exp_bits(d));
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int bd = done_cnt;
    int be = err_cnt;
    int k = 0;
    while (done_cnt == bd && err_cnt == be && k < 20000) begin @(negedge clk); k++; end
    check({tag, "_bound"}, 32'(k < 20000), 32'd1);
    check({tag, "_done"}, 32'(done_cnt - bd), 32'd1);
    check({tag, "_noerr"}, 32'(err_cnt - be), 32'd0);
  endtask

  task automatic check_bits(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(rx_vec), 32'(e));
    end
  endtask

  initial begin
    int bd, be, n, k;
    logic [9:0] e;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_clk_oe", 32'(ps2k_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2k_data_oe), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_err", 32'(tx_err), 32'd0);
    check("rst_ack", 32'(tx_ack_ok), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with ACK
    dev_edges = 11; dev_ack = 1'b1; dev_arm++;
    send(8'hED);
    check("ed_busy", 32'(busy), 32'd1);
    check("ed_ready", 32'(tx_ready), 32'd0);
    wait_frame("ed");
    check_bits("ed_bits");
    check("ed_ack", 32'(tx_ack_ok), 32'd1);

    // 0xF4 with inhibit / RTS timing
    dev_arm++;
    send(8'hF4);
    wait_frame("f4");
    check_bits("f4_bits");
    check("f4_inhibit_len", 32'(inh_len), 32'd6000);
    check("f4_rts_len", 32'(rts_len), 32'd100);
    check("f4_ack", 32'(tx_ack_ok), 32'd1);

    // Device leaves data high at edge 11
    dev_ack = 1'b0; dev_arm++;
    send(8'hFF);
    wait_frame("nack");
    check_bits("nack_bits");
    check("nack_ack", 32'(tx_ack_ok), 32'd0);

    // Device never clocks: timeout
    dev_edges = 0; dev_arm++;
    bd = done_cnt; be = err_cnt;
    send(8'hF4);
    void'(exp_q.pop_back());
    k = 0;
    while (!(busy && !ps2k_clk_oe && ps2k_data_oe) && k < 20000) begin @(negedge clk); k++; end
    check("to_shift_bound", 32'(k < 20000), 32'd1);
    n = 0;
    while (!tx_err && n < TO + 100) begin @(negedge clk); n++; end
    check("to_latency", 32'(n), 32'(TO));
    check("to_clk_oe", 32'(ps2k_clk_oe), 32'd0);
    check("to_data_oe", 32'(ps2k_data_oe), 32'd0);
    check("to_ready", 32'(tx_ready), 32'd1);
    check("to_ack", 32'(tx_ack_ok), 32'd0);
    check("to_nodone", 32'(done_cnt - bd), 32'd0);
    @(negedge clk);
    check("to_err_pulse", 32'(tx_err), 32'd0);
    check("to_err_cnt", 32'(err_cnt - be), 32'd1);

    // Reset after data bit 3
    dev_edges = 4; dev_ack = 1'b1; dev_arm++;
    send(8'hF4);
    k = 0;
    while (dev_served != dev_arm && k < 20000) begin @(negedge clk); k++; end
    check("rst_mid_bound", 32'(k < 20000), 32'd1);
    e = exp_q.pop_front();
    check("rst_mid_bits", 32'(rx_vec[3:0]), 32'(e[3:0]));
    check("rst_mid_pre_oe", 32'(ps2k_data_oe), 32'd1);
    bd = done_cnt; be = err_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_clk_oe", 32'(ps2k_clk_oe), 32'd0);
    check("rst_mid_data_oe", 32'(ps2k_data_oe), 32'd0);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_nodone", 32'(done_cnt - bd), 32'd0);
    check("rst_mid_noerr", 32'(err_cnt - be), 32'd0);
    dev_edges = 11; dev_arm++;
    send(8'hFF);
    wait_frame("after_rst");
    check_bits("after_rst_bits");
    check("after_rst_ack", 32'(tx_ack_ok), 32'd1);

    // Back-to-back with tx_valid held
    bd = acc_cnt;
    dev_arm += 2;
    wait_ready();
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hFF;
    exp_q.push_back(exp_bits(8'hFF));
    k = 0;
    while (!busy && k < 100) begin @(negedge clk); k++; end
    check("b2b_accept1", 32'(busy), 32'd1);
    tx_data = 8'h00;
    exp_q.push_back(exp_bits(8'h00));
    wait_frame("b2b1");
    check("b2b_acc_at_done", 32'(acc_at_done - bd), 32'd1);
    check_bits("b2b1_bits");
    k = 0;
    while (!busy && k < 100) begin @(negedge clk); k++; end
    check("b2b_accept2", 32'(busy), 32'd1);
    tx_valid = 1'b0;
    wait_frame("b2b2");
    check_bits("b2b2_bits");
    check("b2b_acc_cnt", 32'(acc_cnt - bd), 32'd2);
    check("b2b_ack", 32'(tx_ack_ok), 32'd1);

    check("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives the shared PS/2 clock/data lines through open-drain enables.
- Runs the inhibit / request-to-send sequence, shifts out 8 data bits LSB first, odd parity and stop, then samples the device ACK.
- Sits beside the PS/2 keyboard receiver and asserts busy so the receiver can ignore its own outgoing frame.

Parameters:
- INHIBIT_CYC, 6000, clk cycles ps2k_clk is held low before RTS (120 us at 50 MHz).
- RTS_CYC, 100, clk cycles both lines are held low before the clock is released.
- TIMEOUT_CYC, 750000, max clk cycles between device falling edges, or waiting for idle (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- ps2k_clk  in  1  PS/2 clock line, raw, asynchronous
- ps2k_data  in  1  PS/2 data line, raw, asynchronous
- tx_valid  in  1  byte request
- tx_data  in  8  byte to send
- tx_ready  out  1  high when a new byte can be accepted
- ps2k_clk_oe  out  1  1 = pull clock line low, 0 = release
- ps2k_data_oe  out  1  1 = pull data line low, 0 = release
- busy  out  1  high from accept until return to IDLE
- tx_done  out  1  one-cycle pulse at frame end
- tx_ack_ok  out  1  ACK result, valid from tx_done until next accept
- tx_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk.
  - Reset values: ps2k_clk_oe=0, ps2k_data_oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0, tx_ack_ok=0, state IDLE, counters 0.
  - Reset mid-frame releases both lines immediately (asynchronous). No done or err pulse is produced.
- Input synchronisation:
  - ps2k_clk passes through 3 flops r0/r1/r2; neg_edge = ~r1 & r2.
  - ps2k_data passes through 2 flops.
  - All line decisions use the synced values.
- Accept: tx_valid & tx_ready on a rising clk edge.
  - Latch frame = {stop=1, parity=~^tx_data, tx_data}; bit index 0..9.
  - tx_ready falls and busy rises the next cycle. tx_valid while busy is ignored.
- States:
  - IDLE: no lines driven. Go to INHIBIT on accept.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYC cycles, then RTS.
  - RTS: clk_oe=1, data_oe=1 (start bit 0) for RTS_CYC cycles, then SHIFT with clk_oe=0. The timeout counter is cleared on entering SHIFT.
  - SHIFT: on each neg_edge, data_oe = ~frame[idx] and idx++.
    - Falling edges 1..8 present data bits 0..7, edge 9 presents parity, edge 10 presents stop (data_oe=0).
    - After edge 10, go to ACK.
  - ACK: on neg_edge 11, sample synced data and set tx_ack_ok = ~data. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clk=1 and data=1, then pulse tx_done and go to IDLE. tx_ready=1 the following cycle.
- Timeout: a counter clears on every neg_edge in SHIFT/ACK and on entering WAIT_IDLE.
  - If it reaches TIMEOUT_CYC in SHIFT, ACK or WAIT_IDLE: release both lines, pulse tx_err, tx_ack_ok=0, no tx_done, go to IDLE.
  - The counter is 20 bits and saturates; it never wraps.
- Line hold: ps2k_data_oe changes only on neg_edge, or on entry to RTS or IDLE. It is stable while the device samples on the clock high phase.
- tx_done and tx_err are mutually exclusive and never both asserted.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE);
  - command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RSP_ACK=8'hFA, BREAK_CODE=8'hF0.
- Sub-module ps2_sync: 3-flop clock synchroniser plus falling-edge detect and 2-flop data synchroniser. It is reusable by the keyboard receiver.

Test Plan:
- Send 0xED with the device model clocking at a 20 us period and ACK low -> bits on data line 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulse; tx_ack_ok=1.
- Send 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0; ps2k_clk_oe high exactly 6000 cycles, then both oe high exactly 100 cycles.
- Device leaves data high at edge 11 -> tx_done with tx_ack_ok=0.
- Device never clocks after RTS -> tx_err pulse 750000 cycles after SHIFT entry; both oe 0; tx_ready=1.
- rst_n low after data bit 3 -> oe outputs 0 asynchronously; tx_ready=1; no done/err; the next 0xFF sends correctly.
- tx_valid held with 0xFF then 0x00 back-to-back -> second accept only after first tx_done; 0x00 parity 1.
